// File: rtl/bure_mem_arbiter.sv
// Shares one memory request/response port between instruction fetch (read-only) and load/store.
// Default build: fixed LS priority with IF starvation override; define BURE_ARB_RR_EN for round-robin.
module bure_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_if_req_valid,
    output logic                    o_if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_if_req_addr,
    input  logic                    i_if_flush,
    output logic                    o_if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_if_rsp_data,
    input  logic                    i_ls_req_valid,
    output logic                    o_ls_req_ready,
    input  logic                    i_ls_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_ls_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_ls_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_ls_req_wstrb,
    output logic                    o_ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_ls_rsp_data,
    output logic                    o_mem_req_valid,
    input  logic                    i_mem_req_ready,
    output logic                    o_mem_req_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_req_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_req_wstrb,
    input  logic                    i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rsp_data,
    output logic                    o_err
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t                     state_q, state_d;
    logic                       lock_ls_q, lock_ls_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [MAX_OUTSTANDING-1:0] own_ls_q, own_ls_d, disc_q, disc_d;
    logic                       err_q, err_d;

    logic fifo_full, fifo_empty, if_elig, ls_elig, idle_pick_ls;
    logic gnt_valid, gnt_ls, accept, push, pop, head_ls, head_disc;

    assign fifo_full  = (count_q == DEPTH);
    assign fifo_empty = (count_q == '0);
    // Fullness is judged before this cycle's pop, so a returning response never frees a slot early.
    assign if_elig    = i_if_req_valid & ~fifo_full & ~i_if_flush;
    assign ls_elig    = i_ls_req_valid & (i_ls_req_we | ~fifo_full);

`ifdef BURE_ARB_RR_EN
    logic rr_ls_q, rr_ls_d;

    assign idle_pick_ls = ls_elig & (~if_elig | rr_ls_q);
    assign rr_ls_d      = accept ? ~gnt_ls : rr_ls_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) rr_ls_q <= 1'b1;
        else         rr_ls_q <= rr_ls_d;
    end
`else
    localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);
    logic [SC_W-1:0] starve_q, starve_d;
    logic            if_forced;

    assign if_forced    = (STARVE_LIMIT != 0) && (starve_q == SC_MAX);
    assign idle_pick_ls = ls_elig & ~(if_elig & if_forced);

    always_comb begin
        starve_d = starve_q;
        if (accept && !gnt_ls)
            starve_d = '0;
        else if (accept && i_if_req_valid && starve_q != SC_MAX)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) starve_q <= '0;
        else         starve_q <= starve_d;
    end
`endif

    always_comb begin
        gnt_valid = 1'b0;
        gnt_ls    = 1'b0;
        if (state_q == S_LOCK) begin
            gnt_valid = 1'b1;
            gnt_ls    = lock_ls_q;
        end else begin
            gnt_valid = if_elig | ls_elig;
            gnt_ls    = idle_pick_ls;
        end
    end

    assign accept = gnt_valid & i_mem_req_ready;
    assign push   = accept & ~(gnt_ls & i_ls_req_we);
    assign pop    = i_mem_rsp_valid & ~fifo_empty;

    assign o_mem_req_valid = gnt_valid;
    assign o_mem_req_we    = gnt_valid & gnt_ls & i_ls_req_we;
    assign o_mem_req_addr  = !gnt_valid ? '0 : (gnt_ls ? i_ls_req_addr : i_if_req_addr);
    assign o_mem_req_wdata = (gnt_valid & gnt_ls) ? i_ls_req_wdata : '0;
    assign o_mem_req_wstrb = (gnt_valid & gnt_ls) ? i_ls_req_wstrb : '0;
    assign o_if_req_ready  = accept & ~gnt_ls;
    assign o_ls_req_ready  = accept & gnt_ls;

    // A flush in the response cycle also kills the head, since that read predates the flush.
    assign head_ls        = own_ls_q[rd_ptr_q];
    assign head_disc      = disc_q[rd_ptr_q];
    assign o_if_rsp_valid = pop & ~head_ls & ~head_disc & ~i_if_flush;
    assign o_ls_rsp_valid = pop & head_ls;
    assign o_if_rsp_data  = i_mem_rsp_data;
    assign o_ls_rsp_data  = i_mem_rsp_data;
    assign o_err          = err_q;

    always_comb begin
        state_d   = (gnt_valid && !i_mem_req_ready) ? S_LOCK : S_IDLE;
        lock_ls_d = (gnt_valid && !i_mem_req_ready) ? gnt_ls : lock_ls_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        own_ls_d  = own_ls_q;
        disc_d    = disc_q;
        err_d     = err_q | (i_mem_rsp_valid & fifo_empty);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        if (i_if_flush)
            disc_d = disc_q | ~own_ls_q;
        if (pop)
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        if (push) begin
            own_ls_d[wr_ptr_q] = gnt_ls;
            disc_d[wr_ptr_q]   = ~gnt_ls & i_if_flush;
            wr_ptr_d           = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            lock_ls_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            own_ls_q  <= '0;
            disc_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_ls_q <= lock_ls_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            own_ls_q  <= own_ls_d;
            disc_q    <= disc_d;
            err_q     <= err_d;
        end
    end
endmodule
